initial_shift_sequencer: RTL and testbench

Command-side controller for `initial_shift_processor` in the sparse polynomial multiplier.
- Accepts one wrap-around shift command (high and low shift positions).
- Fetches the three boundary words of the dense operand plus the two affected accumulator words.
- Launches the processor, waits for completion, and writes the two XOR results back to accumulator RAM.
- Sits between the sparse-index scheduler (upstream) and the processor plus accumulator RAM (downstream).

---
 rtl/polymult_pkg.sv | 35 +++
 rtl/initial_shift_sequencer.sv | 179 +++++++++++++++++
 tb/tb_initial_shift_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/polymult_pkg.sv
// Shared constants and FSM encoding for the sparse polynomial multiplier.
package polymult_pkg;

    localparam int WORD_WIDTH   = 32;
    localparam int N_BITS       = 17669;
    localparam int LAST_WORD    = 552;
    localparam int TAIL_BITS    = 5;
    localparam int IDX_WIDTH    = 10;
    localparam int SHIFT_WIDTH  = 16;
    localparam int OFFSET_WIDTH = 5;

    // States of the initial-shift command sequencer.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH0 = 4'd1,
        ST_FETCH1 = 4'd2,
        ST_FETCH2 = 4'd3,
        ST_FETCH3 = 4'd4,
        ST_START  = 4'd5,
        ST_WAIT   = 4'd6,
        ST_WB_HI  = 4'd7,
        ST_WB_LO  = 4'd8
    } iss_state_t;

    // Word index holding a given bit position.
    function automatic logic [IDX_WIDTH-1:0] shift_word_idx(input logic [SHIFT_WIDTH-1:0] s);
        return s[OFFSET_WIDTH +: IDX_WIDTH];
    endfunction

    // Bit offset of a given bit position within its word.
    function automatic logic [OFFSET_WIDTH-1:0] shift_bit_off(input logic [SHIFT_WIDTH-1:0] s);
        return s[OFFSET_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/initial_shift_sequencer.sv
// Command-side controller for initial_shift_processor: fetches the dense
// boundary words and the two affected accumulator words, launches the
// processor, then writes both XOR results back to accumulator RAM.
module initial_shift_sequencer
    import polymult_pkg::*;
#(
    parameter int WORD_WIDTH = polymult_pkg::WORD_WIDTH,
    parameter int N_BITS     = polymult_pkg::N_BITS,
    parameter int LAST_WORD  = polymult_pkg::LAST_WORD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [15:0]           cmd_high_shift,
    input  logic [15:0]           cmd_low_shift,
    output logic                  cmd_done,
    output logic                  cmd_err,
    output logic [9:0]            n_addr,
    input  logic [WORD_WIDTH-1:0] n_rdata,
    output logic [9:0]            acc_addr,
    output logic                  acc_we,
    output logic [WORD_WIDTH-1:0] acc_wdata,
    input  logic [WORD_WIDTH-1:0] acc_rdata,
    output logic [WORD_WIDTH-1:0] normal_word_zero,
    output logic [WORD_WIDTH-1:0] normal_word_551,
    output logic [WORD_WIDTH-1:0] normal_word_552,
    output logic [WORD_WIDTH-1:0] acc_word_high,
    output logic [WORD_WIDTH-1:0] acc_word_low,
    output logic [15:0]           high_shift,
    output logic [15:0]           low_shift,
    output logic [9:0]            acc_start_idx_high,
    output logic [9:0]            acc_start_idx_low,
    output logic [4:0]            acc_shift_idx_high,
    output logic [4:0]            acc_shift_idx_low,
    output logic                  start_process,
    input  logic [WORD_WIDTH-1:0] high_result,
    input  logic [WORD_WIDTH-1:0] low_result,
    input  logic                  processing_done
);

    localparam logic [15:0] N_BITS_W    = 16'(N_BITS);
    localparam logic [9:0]  ADDR_LAST   = 10'(LAST_WORD);
    localparam logic [9:0]  ADDR_PENULT = 10'(LAST_WORD - 1);

    iss_state_t state_reg, state_next;

    logic [WORD_WIDTH-1:0] word_zero_reg, word_551_reg, word_552_reg;
    logic [WORD_WIDTH-1:0] acc_high_reg, acc_low_reg;
    logic [15:0]           high_shift_reg, low_shift_reg;
    logic [9:0]            idx_high_reg, idx_low_reg;
    logic [4:0]            off_high_reg, off_low_reg;
    logic                  start_reg, err_reg;

    logic range_bad;
    logic accept;
    logic idx_equal;

    assign range_bad = (cmd_high_shift >= N_BITS_W) || (cmd_low_shift >= N_BITS_W);
    assign accept    = (state_reg == ST_IDLE) && cmd_valid && !range_bad;
    // Both results land in the same accumulator word: merge into one write.
    assign idx_equal = (idx_high_reg == idx_low_reg);

    // State register plus every captured operand; reset aborts everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            word_zero_reg  <= '0;
            word_551_reg   <= '0;
            word_552_reg   <= '0;
            acc_high_reg   <= '0;
            acc_low_reg    <= '0;
            high_shift_reg <= '0;
            low_shift_reg  <= '0;
            idx_high_reg   <= '0;
            idx_low_reg    <= '0;
            off_high_reg   <= '0;
            off_low_reg    <= '0;
            start_reg      <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            start_reg <= (state_next == ST_START);
            err_reg   <= (state_reg == ST_IDLE) && cmd_valid && range_bad;
            if (accept) begin
                high_shift_reg <= cmd_high_shift;
                low_shift_reg  <= cmd_low_shift;
                idx_high_reg   <= shift_word_idx(cmd_high_shift);
                idx_low_reg    <= shift_word_idx(cmd_low_shift);
                off_high_reg   <= shift_bit_off(cmd_high_shift);
                off_low_reg    <= shift_bit_off(cmd_low_shift);
            end
            // Read data arrives one cycle after the address was presented.
            if (state_reg == ST_FETCH1) begin
                word_zero_reg <= n_rdata;
                acc_high_reg  <= acc_rdata;
            end
            if (state_reg == ST_FETCH2) begin
                word_551_reg <= n_rdata;
                acc_low_reg  <= acc_rdata;
            end
            if (state_reg == ST_FETCH3) begin
                word_552_reg <= n_rdata;
            end
        end
    end

    // Next-state logic and RAM-side strobes decoded from the current state.
    always_comb begin
        state_next = state_reg;
        n_addr     = '0;
        acc_addr   = '0;
        acc_we     = 1'b0;
        acc_wdata  = '0;
        cmd_done   = 1'b0;
        cmd_ready  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (accept) state_next = ST_FETCH0;
            end
            ST_FETCH0: begin
                n_addr     = '0;
                acc_addr   = idx_high_reg;
                state_next = ST_FETCH1;
            end
            ST_FETCH1: begin
                n_addr     = ADDR_PENULT;
                acc_addr   = idx_low_reg;
                state_next = ST_FETCH2;
            end
            ST_FETCH2: begin
                n_addr     = ADDR_LAST;
                state_next = ST_FETCH3;
            end
            ST_FETCH3: state_next = ST_START;
            // Done is not looked at here: it may still be high from the last run.
            ST_START:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (processing_done) state_next = ST_WB_HI;
            end
            ST_WB_HI: begin
                acc_addr = idx_high_reg;
                acc_we   = 1'b1;
                if (idx_equal) begin
                    acc_wdata  = high_result ^ low_result ^ acc_high_reg;
                    cmd_done   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    acc_wdata  = high_result;
                    state_next = ST_WB_LO;
                end
            end
            ST_WB_LO: begin
                acc_addr   = idx_low_reg;
                acc_we     = 1'b1;
                acc_wdata  = low_result;
                cmd_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cmd_err            = err_reg;
    assign start_process      = start_reg;
    assign normal_word_zero   = word_zero_reg;
    assign normal_word_551    = word_551_reg;
    assign normal_word_552    = word_552_reg;
    assign acc_word_high      = acc_high_reg;
    assign acc_word_low       = acc_low_reg;
    assign high_shift         = high_shift_reg;
    assign low_shift          = low_shift_reg;
    assign acc_start_idx_high = idx_high_reg;
    assign acc_start_idx_low  = idx_low_reg;
    assign acc_shift_idx_high = off_high_reg;
    assign acc_shift_idx_low  = off_low_reg;

endmodule

// File: tb/tb_initial_shift_sequencer.sv
// Bench for initial_shift_sequencer: RAM and processor stubs plus a per-cycle
// expected-timeline model derived from the command schedule.
module tb_initial_shift_sequencer;

    localparam int MAXC = 1024;
    localparam int NB   = 17669;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_high_shift = '0;
    logic [15:0] cmd_low_shift = '0;
    logic        cmd_done, cmd_err;
    logic [9:0]  n_addr, acc_addr;
    logic [31:0] n_rdata = '0;
    logic        acc_we;
    logic [31:0] acc_wdata;
    logic [31:0] acc_rdata = '0;
    logic [31:0] normal_word_zero, normal_word_551, normal_word_552;
    logic [31:0] acc_word_high, acc_word_low;
    logic [15:0] high_shift, low_shift;
    logic [9:0]  acc_start_idx_high, acc_start_idx_low;
    logic [4:0]  acc_shift_idx_high, acc_shift_idx_low;
    logic        start_process;
    logic [31:0] high_result, low_result;
    logic        processing_done;

    initial_shift_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_high_shift(cmd_high_shift), .cmd_low_shift(cmd_low_shift),
        .cmd_done(cmd_done), .cmd_err(cmd_err),
        .n_addr(n_addr), .n_rdata(n_rdata),
        .acc_addr(acc_addr), .acc_we(acc_we), .acc_wdata(acc_wdata), .acc_rdata(acc_rdata),
        .normal_word_zero(normal_word_zero), .normal_word_551(normal_word_551),
        .normal_word_552(normal_word_552), .acc_word_high(acc_word_high), .acc_word_low(acc_word_low),
        .high_shift(high_shift), .low_shift(low_shift),
        .acc_start_idx_high(acc_start_idx_high), .acc_start_idx_low(acc_start_idx_low),
        .acc_shift_idx_high(acc_shift_idx_high), .acc_shift_idx_low(acc_shift_idx_low),
        .start_process(start_process),
        .high_result(high_result), .low_result(low_result),
        .processing_done(processing_done)
    );

    always #5 clk = ~clk;

    // Memories with one-cycle registered reads.
    logic [31:0] n_mem   [MAXC];
    logic [31:0] acc_mem [MAXC];
    logic [31:0] mdl_acc [MAXC];

    always @(posedge clk) begin
        n_rdata   <= n_mem[n_addr];
        acc_rdata <= acc_mem[acc_addr];
        if (acc_we) acc_mem[acc_addr] <= acc_wdata;
    end

    // Processor stub: done falls on launch and rises stub_lat cycles later.
    int   stub_lat = 4;
    int   stub_cnt;
    logic stub_done;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
        end else if (start_process) begin
            stub_cnt  <= stub_lat;
            stub_done <= 1'b0;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_done <= 1'b1;
        end
    end
    assign processing_done = stub_done;
    assign high_result = acc_word_high ^ normal_word_zero ^ normal_word_551 ^ {high_shift, 16'hA5A5};
    assign low_result  = acc_word_low ^ normal_word_552 ^ {low_shift, 16'h5A5A};

    // Expected timeline, indexed by cycle number.
    typedef struct {
        logic [15:0] hs, ls;
        logic [31:0] n0, n551, n552, ah, al;
    } op_t;

    bit          exp_ready [MAXC];
    bit          exp_start [MAXC];
    bit          exp_done  [MAXC];
    bit          exp_err   [MAXC];
    bit          exp_we    [MAXC];
    int          exp_n     [MAXC];
    int          exp_a     [MAXC];
    logic [31:0] exp_wd    [MAXC];
    bit          exp_opchk [MAXC];
    op_t         exp_op    [MAXC];

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            exp_ready[i] = 1'b1; exp_start[i] = 1'b0; exp_done[i] = 1'b0;
            exp_err[i] = 1'b0; exp_we[i] = 1'b0; exp_n[i] = -1; exp_a[i] = -1;
            exp_wd[i] = '0; exp_opchk[i] = 1'b0;
        end
    endtask

    // Schedule the expected behaviour of a command accepted in cycle c0 whose
    // processor answers L cycles after launch.
    task automatic plan(input int c0, input logic [15:0] hs, input logic [15:0] ls,
                        input int L, input bit commit);
        int ih, il, last;
        op_t o;
        logic [31:0] hr, lr;
        if (int'(hs) >= NB || int'(ls) >= NB) begin
            exp_err[c0 + 1] = 1'b1;
            return;
        end
        ih = int'(hs) / 32;
        il = int'(ls) / 32;
        o.hs = hs; o.ls = ls;
        o.n0 = n_mem[0]; o.n551 = n_mem[551]; o.n552 = n_mem[552];
        o.ah = mdl_acc[ih]; o.al = mdl_acc[il];
        hr = o.ah ^ o.n0 ^ o.n551 ^ {hs, 16'hA5A5};
        lr = o.al ^ o.n552 ^ {ls, 16'h5A5A};
        last = (ih == il) ? c0 + 7 + L : c0 + 8 + L;
        for (int c = c0 + 1; c <= last; c++) exp_ready[c] = 1'b0;
        exp_n[c0 + 1] = 0;   exp_a[c0 + 1] = ih;
        exp_n[c0 + 2] = 551; exp_a[c0 + 2] = il;
        exp_n[c0 + 3] = 552;
        exp_start[c0 + 5] = 1'b1;
        exp_opchk[c0 + 5] = 1'b1; exp_op[c0 + 5] = o;
        exp_we[c0 + 7 + L] = 1'b1; exp_a[c0 + 7 + L] = ih;
        exp_opchk[c0 + 7 + L] = 1'b1; exp_op[c0 + 7 + L] = o;
        if (ih == il) begin
            exp_wd[c0 + 7 + L] = hr ^ lr ^ o.ah;
            exp_done[c0 + 7 + L] = 1'b1;
            if (commit) mdl_acc[ih] = hr ^ lr ^ o.ah;
        end else begin
            exp_wd[c0 + 7 + L] = hr;
            exp_we[c0 + 8 + L] = 1'b1; exp_a[c0 + 8 + L] = il; exp_wd[c0 + 8 + L] = lr;
            exp_done[c0 + 8 + L] = 1'b1;
            if (commit) begin
                mdl_acc[ih] = hr;
                mdl_acc[il] = lr;
            end
        end
    endtask

    // Compare every DUT output against the timeline on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", 32'(cmd_ready), 32'd1);
            chk("rst_strobes", 32'({cmd_done, cmd_err, acc_we, start_process}), 32'd0);
            chk("rst_addr", 32'({n_addr, acc_addr}), 32'd0);
            chk("rst_wdata", acc_wdata, 32'd0);
            chk("rst_operands", 32'(|{normal_word_zero, normal_word_551, normal_word_552,
                acc_word_high, acc_word_low, high_shift, low_shift, acc_start_idx_high,
                acc_start_idx_low, acc_shift_idx_high, acc_shift_idx_low}), 32'd0);
        end else if (cyc < MAXC) begin
            chk("ready", 32'(cmd_ready), 32'(exp_ready[cyc]));
            chk("start", 32'(start_process), 32'(exp_start[cyc]));
            chk("done", 32'(cmd_done), 32'(exp_done[cyc]));
            chk("err", 32'(cmd_err), 32'(exp_err[cyc]));
            chk("acc_we", 32'(acc_we), 32'(exp_we[cyc]));
            if (exp_n[cyc] >= 0) chk("n_addr", 32'(n_addr), 32'(exp_n[cyc]));
            if (exp_a[cyc] >= 0) chk("acc_addr", 32'(acc_addr), 32'(exp_a[cyc]));
            if (exp_we[cyc]) chk("acc_wdata", acc_wdata, exp_wd[cyc]);
            if (exp_opchk[cyc]) begin
                chk("op_high_shift", 32'(high_shift), 32'(exp_op[cyc].hs));
                chk("op_low_shift", 32'(low_shift), 32'(exp_op[cyc].ls));
                chk("op_idx_high", 32'(acc_start_idx_high), 32'(exp_op[cyc].hs / 16'd32));
                chk("op_idx_low", 32'(acc_start_idx_low), 32'(exp_op[cyc].ls / 16'd32));
                chk("op_off_high", 32'(acc_shift_idx_high), 32'(exp_op[cyc].hs % 16'd32));
                chk("op_off_low", 32'(acc_shift_idx_low), 32'(exp_op[cyc].ls % 16'd32));
                chk("op_word_zero", normal_word_zero, exp_op[cyc].n0);
                chk("op_word_551", normal_word_551, exp_op[cyc].n551);
                chk("op_word_552", normal_word_552, exp_op[cyc].n552);
                chk("op_acc_high", acc_word_high, exp_op[cyc].ah);
                chk("op_acc_low", acc_word_low, exp_op[cyc].al);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one command for a single cycle and schedule its expectations.
    task automatic present(input logic [15:0] hs, input logic [15:0] ls, input int L, input bit commit);
        cmd_valid = 1'b1;
        cmd_high_shift = hs;
        cmd_low_shift = ls;
        stub_lat = L;
        plan(cyc, hs, ls, L, commit);
        $display("[TB] cmd high=%0d low=%0d lat=%0d at cycle %0d", hs, ls, L, cyc);
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [15:0] hs, input logic [15:0] ls, input int L);
        present(hs, ls, L, 1'b1);
        tick(L + 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, bad;
        for (int i = 0; i < MAXC; i++) begin
            n_mem[i] = 32'(i) * 32'h9E3779B1;
            acc_mem[i] = '0;
            mdl_acc[i] = '0;
        end
        n_mem[0] = 32'h1111_0000;
        n_mem[551] = 32'h0000_2222;
        n_mem[552] = 32'h0000_001F;
        clear_from(0);

        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Normal command: word 1 and word 531.
        run_cmd(16'd40, 16'd17000, 4);
        chk("lit_acc1", acc_mem[1], 32'h1139_8787);
        chk("lit_acc531", acc_mem[531], 32'h4268_5A45);
        chk("lit_model_acc1", mdl_acc[1], 32'h1139_8787);

        // Merged indices: both shifts in word 1.
        run_cmd(16'd37, 16'd60, 4);
        chk("lit_merged_acc1", acc_mem[1], 32'h0031_5A45);
        chk("lit_model_merged", mdl_acc[1], 32'h0031_5A45);

        // Out-of-range shifts are rejected without RAM traffic.
        present(16'd17669, 16'd5, 4, 1'b1);
        tick(3);
        present(16'd100, 16'd20000, 4, 1'b1);
        tick(3);

        // Largest legal shift lands in the final partial word.
        run_cmd(16'd17668, 16'd0, 4);

        // Slow processor; done is still high from the previous run at START.
        run_cmd(16'd1000, 16'd2000, 20);

        // Reset during WAIT aborts the command with no write.
        present(16'd3000, 16'd4000, 20, 1'b0);
        tick(8);
        clear_from(cyc);
        rst_n = 1'b0;
        $display("[TB] reset asserted at cycle %0d", cyc);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        run_cmd(16'd6000, 16'd7000, 4);

        // Back-to-back with cmd_valid held: acceptances at c0, c0+13, c0+26.
        c0 = cyc;
        cmd_valid = 1'b1;
        cmd_high_shift = 16'd64; cmd_low_shift = 16'd96; stub_lat = 4;
        plan(c0, 16'd64, 16'd96, 4, 1'b1);
        $display("[TB] b2b cmd high=64 low=96 at cycle %0d", c0);
        tick(1);
        cmd_high_shift = 16'd65; cmd_low_shift = 16'd5000;
        plan(c0 + 13, 16'd65, 16'd5000, 4, 1'b1);
        $display("[TB] b2b cmd high=65 low=5000 at cycle %0d", c0 + 13);
        tick(13);
        cmd_high_shift = 16'd17600; cmd_low_shift = 16'd33;
        plan(c0 + 26, 16'd17600, 16'd33, 4, 1'b1);
        $display("[TB] b2b cmd high=17600 low=33 at cycle %0d", c0 + 26);
        tick(13);
        cmd_valid = 1'b0;
        tick(16);

        bad = 0;
        for (int i = 0; i <= 552; i++) if (acc_mem[i] !== mdl_acc[i]) bad++;
        chk("acc_ram_final", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
